// File: rtl/fetch_pc_unit_pkg.sv
// Shared front-end constants: fetch FSM state encodings, branch func3 codes
// and the PC increment helper.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    FPU_IDLE  = 2'd0,
    FPU_REQ   = 2'd1,
    FPU_HOLD  = 2'd2,
    FPU_DRAIN = 2'd3
  } fpu_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and single-outstanding imem request FSM with
// branch/jump redirect, wrong-path discard and IF/ID flush.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_ex_valid,
  input  logic        i_is_branch,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic [31:0] i_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  output logic        o_fetch_valid,
  output logic [31:0] o_fetch_pc,
  output logic        o_flush,
  output logic        o_misaligned,
  output logic [31:0] o_redirect_cnt
);

  fpu_state_e  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] tgt_q, tgt_nxt;
  logic        redirect_evt, target_ok, accept, fire, run_req;
  fpu_state_e  run_state;

  assign redirect_evt = i_ex_valid && ((i_is_branch && i_branch) || i_jump);
  assign target_ok    = (i_target[1:0] == 2'b00);
  assign accept       = redirect_evt && target_ok;
  assign run_state    = i_stall ? FPU_HOLD : FPU_REQ;

  // Request is a pure decode of registered state, so stall cannot retract it.
  assign run_req     = (state == FPU_REQ) || (state == FPU_DRAIN);
  assign o_imem_req  = run_req;
  assign o_imem_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt_nxt   = tgt_q;
    fire      = 1'b0;
    unique case (state)
      FPU_IDLE: begin
        if (accept) pc_nxt = i_target;
        state_nxt = run_state;
      end
      FPU_REQ: begin
        if (i_imem_ack) begin
          if (accept) begin
            pc_nxt = i_target;
          end else begin
            fire   = 1'b1;
            pc_nxt = pc_inc(pc);
          end
          state_nxt = run_state;
        end else if (accept) begin
          tgt_nxt   = i_target;
          state_nxt = FPU_DRAIN;
        end
      end
      FPU_HOLD: begin
        if (accept) pc_nxt = i_target;
        state_nxt = run_state;
      end
      FPU_DRAIN: begin
        if (accept) tgt_nxt = i_target;
        if (i_imem_ack) begin
          // A redirect arriving with the ack is newer than the held target.
          pc_nxt    = accept ? i_target : tgt_q;
          state_nxt = run_state;
        end
      end
      default: state_nxt = FPU_IDLE;
    endcase
  end

  // Stage boundary: control state, PC and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= FPU_IDLE;
      pc            <= RESET_PC;
      o_fetch_valid <= 1'b0;
      o_fetch_pc    <= 32'h0;
      o_flush       <= 1'b0;
      o_misaligned  <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      o_fetch_valid <= fire;
      if (fire) o_fetch_pc <= pc;
      o_flush       <= accept || (state_nxt == FPU_DRAIN);
      o_misaligned  <= redirect_evt && !target_ok;
    end
  end

  always_ff @(posedge i_clk) begin
    tgt_q <= tgt_nxt;
  end

  sat_counter #(
    .WIDTH(32)
  ) u_redirect_cnt (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .en   (accept),
    .count(o_redirect_cnt)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scenario bench for fetch_pc_unit with a fetch-PC scoreboard queue.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, ex_valid, is_branch, branch, jump, ack;
  logic [31:0] target;
  logic        imem_req, fetch_valid, flush, misaligned;
  logic [31:0] imem_addr, fetch_pc, redirect_cnt;

  logic        sc_en;
  logic [2:0]  sc_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_ex_valid    (ex_valid),
    .i_is_branch   (is_branch),
    .i_branch      (branch),
    .i_jump        (jump),
    .i_target      (target),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (ack),
    .o_fetch_valid (fetch_valid),
    .o_fetch_pc    (fetch_pc),
    .o_flush       (flush),
    .o_misaligned  (misaligned),
    .o_redirect_cnt(redirect_cnt)
  );

  sat_counter #(.WIDTH(3)) u_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sc_en),
    .count(sc_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_fetch_valid", 32'(fetch_valid), 32'd0);
      else chk("fetch_pc", fetch_pc, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    ex_valid = 0; is_branch = 0; branch = 0; jump = 0; target = 32'h0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    ex_valid = 1; jump = 1; target = t;
  endtask

  // One acked fetch expected to complete normally at address a.
  task automatic fetch_ok(input string tag, input logic [31:0] a);
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_addr"}, imem_addr, a);
    ack = 1;
    exp_q.push_back(a);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; stall = 0; ack = 0; sc_en = 0;
    clear_redirect();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_cnt", redirect_cnt, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);

    @(negedge clk);
    rst_n = 1;
    ack = 1;
    step();
    chk("first_req", 32'(imem_req), 32'd1);

    // Streaming with ack tied high.
    fetch_ok("s0", 32'h100);
    fetch_ok("s1", 32'h104);
    fetch_ok("s2", 32'h108);
    chk("s_valid_each_cycle", 32'(fetch_valid), 32'd1);

    // Taken branch with same-cycle ack at 0x10C.
    chk("br_addr", imem_addr, 32'h10C);
    ex_valid = 1; is_branch = 1; branch = 1; target = 32'h200; ack = 1;
    step();
    clear_redirect();
    ack = 0;
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_addr_next", imem_addr, 32'h200);
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_cnt", redirect_cnt, 32'd1);
    step();
    chk("br_flush_pulse", 32'(flush), 32'd0);
    fetch_ok("br_f", 32'h200);

    // Jump with delayed ack, second jump during DRAIN.
    ack = 0;
    do_jump(32'h300);
    step();
    clear_redirect();
    chk("dr_flush0", 32'(flush), 32'd1);
    chk("dr_addr0", imem_addr, 32'h204);
    chk("dr_req0", 32'(imem_req), 32'd1);
    step();
    chk("dr_flush1", 32'(flush), 32'd1);
    do_jump(32'h400);
    step();
    clear_redirect();
    chk("dr_flush2", 32'(flush), 32'd1);
    chk("dr_addr2", imem_addr, 32'h204);
    ack = 1;
    step();
    ack = 0;
    chk("dr_addr_after", imem_addr, 32'h400);
    chk("dr_flush_after", 32'(flush), 32'd0);
    chk("dr_cnt", redirect_cnt, 32'd3);

    // Stall during outstanding request.
    stall = 1;
    step();
    chk("st_req_held", 32'(imem_req), 32'd1);
    chk("st_addr_held", imem_addr, 32'h400);
    fetch_ok("st_f", 32'h400);
    ack = 0;
    chk("st_req_drop", 32'(imem_req), 32'd0);
    step();
    chk("st_hold_req", 32'(imem_req), 32'd0);
    stall = 0;
    step();
    chk("st_resume_req", 32'(imem_req), 32'd1);
    chk("st_resume_addr", imem_addr, 32'h404);
    stall = 1;
    fetch_ok("st_f2", 32'h404);
    ack = 0;
    do_jump(32'h500);
    step();
    clear_redirect();
    chk("hold_redirect_req", 32'(imem_req), 32'd0);
    chk("hold_redirect_addr", imem_addr, 32'h500);
    chk("hold_redirect_flush", 32'(flush), 32'd1);
    chk("hold_redirect_cnt", redirect_cnt, 32'd4);
    stall = 0;
    step();
    chk("hold_resume_addr", imem_addr, 32'h500);

    // Misaligned target is ignored.
    do_jump(32'h202);
    step();
    clear_redirect();
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_flush", 32'(flush), 32'd0);
    chk("mis_cnt", redirect_cnt, 32'd4);
    chk("mis_addr", imem_addr, 32'h500);
    step();
    chk("mis_pulse_end", 32'(misaligned), 32'd0);

    // PC wrap.
    do_jump(32'hFFFF_FFFC);
    ack = 1;
    step();
    clear_redirect();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    fetch_ok("wrap_f", 32'hFFFF_FFFC);
    chk("wrap_addr1", imem_addr, 32'h0);

    // Reset in the middle of DRAIN with an ack in flight.
    ack = 0;
    do_jump(32'h600);
    step();
    clear_redirect();
    chk("rd_flush", 32'(flush), 32'd1);
    @(negedge clk);
    ack = 1;
    rst_n = 0;
    #1;
    chk("rd_req_drop", 32'(imem_req), 32'd0);
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_cnt", redirect_cnt, 32'd0);
    chk("rd_flush_clr", 32'(flush), 32'd0);
    step();
    ack = 0;
    @(negedge clk);
    rst_n = 1;

    // Saturation of the counter primitive, narrow instance.
    sc_en = 1;
    repeat (9) step();
    sc_en = 0;
    chk("sat_hold", 32'(sc_count), 32'd7);

    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
